// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle for decoder_rr_arbiter.
// The master side drives requests and done; the slave (arbiter) side drives the grant outputs.
interface decoder_rr_arbiter_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  modport master (
    output req, done,
    input  gnt, gnt_idx, gnt_vld, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_idx, gnt_vld, timeout
  );
endinterface

// File: rtl/decoder_rr_arbiter.sv
// Eight-way round-robin arbiter with registered one-hot and binary grant outputs.
// Define ARB_TIMEOUT_EN to build the hold counter that forces release after HOLD_MAX cycles.
module decoder_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 15
) (
  input logic                 clk,
  input logic                 rst_n,
  decoder_rr_arbiter_if.slave arb_if
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] idx_q, idx_d;
  logic       vld_q, vld_d;
  logic [7:0] gnt_q, gnt_d;

  logic [2:0] cand;
  logic [2:0] pick;
  logic       pick_vld;
  logic       hold;
  logic       force_rel;

  // First requester at or after ptr_q, wrapping modulo 8.
  always_comb begin
    cand     = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!pick_vld && arb_if.req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  // Owner keeps the grant while it still requests and has not signalled done.
  assign hold = arb_if.req[idx_q] && !arb_if.done;

`ifdef ARB_TIMEOUT_EN
  localparam logic [3:0] HoldLast = 4'(HOLD_MAX - 1);

  logic [3:0] cnt_q, cnt_d;
  logic       to_q;

  // A simultaneous normal release leaves hold low, so it never counts as a timeout.
  assign force_rel = (state_q == StGrant) && hold && (cnt_q == HoldLast);

  // Counter restarts at every new grant and advances while the grant is kept.
  always_comb begin
    cnt_d = '0;
    if (state_q == StGrant && state_d == StGrant) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Hold counter and timeout pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= force_rel;
    end
  end

  assign arb_if.timeout = to_q;
`else
  logic unused_hold_max;

  assign unused_hold_max = ^HOLD_MAX;
  assign force_rel       = 1'b0;
  assign arb_if.timeout  = 1'b0;
`endif

  // Next-state logic: grant from idle, release to idle and advance the pointer past the owner.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    vld_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          idx_d   = pick;
          vld_d   = 1'b1;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (!hold || force_rel) begin
          ptr_d   = idx_q + 3'd1;
          state_d = StIdle;
        end else begin
          vld_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    gnt_d = vld_d ? (8'b1 << idx_d) : 8'h00;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      gnt_q   <= gnt_d;
    end
  end

  assign arb_if.gnt     = gnt_q;
  assign arb_if.gnt_idx = idx_q;
  assign arb_if.gnt_vld = vld_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter: expected outputs are queued as each step is driven
// and compared one cycle later, just after the clock edge.
module tb_decoder_rr_arbiter;

  logic clk;
  logic rst_n;

  decoder_rr_arbiter_if bus ();

  decoder_rr_arbiter #(
    .HOLD_MAX(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb_if(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] gnt;
    logic       vld;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Queue the expected outputs for the next edge, advance one cycle, then compare.
  task automatic cyc(input string tag, input logic [7:0] g, input logic v, input logic t);
    exp_t e;
    e.tag = tag;
    e.gnt = g;
    e.vld = v;
    e.to  = t;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, "/gnt"}, bus.gnt, e.gnt);
    chk({e.tag, "/vld"}, 8'(bus.gnt_vld), 8'(e.vld));
    chk({e.tag, "/timeout"}, 8'(bus.timeout), 8'(e.to));
    if (e.vld) chk({e.tag, "/idx"}, 8'(bus.gnt_idx), 8'(oh2idx(e.gnt)));
  endtask

  initial begin
    rst_n    = 1'b0;
    bus.req  = 8'hFF;
    bus.done = 1'b0;

    // Reset dominates a full request vector.
    for (int i = 0; i < 3; i++) cyc("reset", 8'h00, 1'b0, 1'b0);

    // Two requesters: 0 first, one idle cycle, then 2.
    rst_n   = 1'b1;
    bus.req = 8'h05;
    cyc("r05_g0", 8'h01, 1'b1, 1'b0);
    bus.done = 1'b1;
    cyc("r05_rel0", 8'h00, 1'b0, 1'b0);
    bus.done = 1'b0;
    cyc("r05_g2", 8'h04, 1'b1, 1'b0);
    bus.done = 1'b1;
    cyc("r05_rel2", 8'h00, 1'b0, 1'b0);
    bus.done = 1'b0;
    bus.req  = 8'h00;
    cyc("idle_noreq", 8'h00, 1'b0, 1'b0);
    bus.done = 1'b1;
    cyc("idle_done", 8'h00, 1'b0, 1'b0);

    // Full rotation with wrap back to requester 0.
    rst_n    = 1'b0;
    bus.done = 1'b0;
    cyc("reset2", 8'h00, 1'b0, 1'b0);
    rst_n   = 1'b1;
    bus.req = 8'hFF;
    cyc("rot_g0", 8'h01, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      bus.done = 1'b1;
      cyc("rot_gap", 8'h00, 1'b0, 1'b0);
      bus.done = 1'b0;
      cyc("rot_g", 8'(8'h01 << (k % 8)), 1'b1, 1'b0);
    end
    bus.done = 1'b1;
    cyc("rot_end", 8'h00, 1'b0, 1'b0);

    // Release of 5 moves the pointer to 6; search must wrap to 0.
    bus.done = 1'b0;
    bus.req  = 8'h20;
    cyc("g5", 8'h20, 1'b1, 1'b0);
    bus.done = 1'b1;
    cyc("rel5", 8'h00, 1'b0, 1'b0);
    bus.done = 1'b0;
    bus.req  = 8'h21;
    cyc("wrap_g0", 8'h01, 1'b1, 1'b0);
    bus.done = 1'b1;
    cyc("wrap_rel0", 8'h00, 1'b0, 1'b0);

    // Long hold of requester 3.
    bus.done = 1'b0;
    bus.req  = 8'h08;
    cyc("hold_g3", 8'h08, 1'b1, 1'b0);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) cyc("hold_t", 8'h08, 1'b1, 1'b0);
    cyc("timeout", 8'h00, 1'b0, 1'b1);
    cyc("regrant3", 8'h08, 1'b1, 1'b0);
    cyc("hold_t2", 8'h08, 1'b1, 1'b0);
    cyc("hold_t2", 8'h08, 1'b1, 1'b0);
    cyc("hold_t2", 8'h08, 1'b1, 1'b0);
    bus.done = 1'b1;
    cyc("done_at_limit", 8'h00, 1'b0, 1'b0);
    bus.done = 1'b0;
    cyc("regrant3b", 8'h08, 1'b1, 1'b0);
`else
    for (int i = 0; i < 6; i++) cyc("hold_forever", 8'h08, 1'b1, 1'b0);
    bus.req = 8'hFF;
    for (int i = 0; i < 6; i++) cyc("hold_ignore_others", 8'h08, 1'b1, 1'b0);
    bus.req = 8'h08;
`endif

    // Reset in the middle of a grant, then arbitration restarts from pointer 0.
    rst_n = 1'b0;
    cyc("mid_reset", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc("post_reset_g3", 8'h08, 1'b1, 1'b0);
    rst_n   = 1'b0;
    bus.req = 8'h90;
    cyc("reset3", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc("ptr0_g4", 8'h10, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decoder_rr_arbiter.md
DECODER_RR_ARBITER -- requirements
Module: decoder_rr_arbiter

Interface
REQ-001 SHALL have parameter HOLD_MAX, default 15, max grant cycles before forced release; legal range 2..15; used only when ARB_TIMEOUT_EN is defined.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-004 SHALL have port req, input, 8, request vector; bit i = requester i.
REQ-005 SHALL have port done, input, 1, current owner releases the resource.
REQ-006 SHALL have port gnt, output, 8, registered one-hot grant (3-to-8 decode of gnt_idx, gated by gnt_vld).
REQ-007 SHALL have port gnt_idx, output, 3, registered binary index of the current owner.
REQ-008 SHALL have port gnt_vld, output, 1, registered; high while a grant is held.
REQ-009 SHALL have port timeout, output, 1, registered; one-cycle pulse on forced release.

Function
REQ-010 SHALL implement two states: IDLE and GRANT.
REQ-011 SHALL keep a 3-bit priority pointer ptr; search order is ptr, ptr+1, ..., ptr+7, all mod 8.
REQ-012 IDLE, req != 0: at the edge, select the first set bit in search order, load gnt_idx, set gnt_vld=1, go to GRANT; grant is visible the cycle after req is sampled (1-cycle latency).
REQ-013 IDLE, req == 0: stay in IDLE; gnt=0, gnt_vld=0, gnt_idx holds its value.
REQ-014 gnt SHALL equal 8'b1 << gnt_idx when gnt_vld=1, else 8'h00; never more than one bit set.
REQ-015 GRANT: hold the grant while req[gnt_idx]=1 and done=0; changes on other req bits are ignored.
REQ-016 GRANT, done=1 or req[gnt_idx]=0: at the edge, clear gnt_vld, set ptr=gnt_idx+1 (7 wraps to 0), go to IDLE.
REQ-017 A release SHALL be followed by exactly one IDLE cycle with gnt=0 before any new grant.
REQ-018 done while in IDLE SHALL be ignored.
REQ-019 timeout SHALL be 0 except as defined in REQ-025.

Reset
REQ-020 With rst_n=0 at an edge: state=IDLE, ptr=0, gnt=8'h00, gnt_idx=0, gnt_vld=0, timeout=0, hold counter=0.
REQ-021 Reset SHALL override all other inputs, including in the middle of a grant; the grant drops at that edge.
REQ-022 On the first edge with rst_n=1, arbitration SHALL start from ptr=0.

Configuration
REQ-023 Macro ARB_TIMEOUT_EN SHALL compile the hold-timeout feature in or out.
REQ-024 When defined: a 4-bit hold counter clears on entering GRANT and increments each cycle in GRANT.
REQ-025 When defined: if the counter reaches HOLD_MAX-1 while the hold condition of REQ-015 is still true, the block SHALL force a release as in REQ-016 and pulse timeout=1 for that one cycle (the cycle gnt_vld falls).
REQ-026 When defined: a normal release in the same cycle as a timeout SHALL count as a normal release, with timeout=0.
REQ-027 When not defined: no counter is built, timeout is tied to 0, and grants are held for any length of time.

Verification
REQ-028 Reset with req=8'hFF -> gnt=8'h00, gnt_vld=0, timeout=0 throughout reset.
REQ-029 After reset, req=8'h05 held, done pulsed once the grant is seen -> gnt=8'h01, then one cycle of 8'h00, then 8'h04.
REQ-030 req=8'hFF held, done pulsed on each grant -> gnt sequence 01,02,04,08,10,20,40,80,01 (wrap), with an 8'h00 cycle between each.
REQ-031 After grant and release of idx 5 (ptr=6), req=8'h21 -> gnt_idx=0, gnt=8'h01 (search wraps past 7).
REQ-032 ARB_TIMEOUT_EN defined, HOLD_MAX=4, req=8'h08 held, done=0 -> gnt=8'h08 for 4 cycles, timeout pulse, one idle cycle, then gnt=8'h08 again; macro undefined -> gnt=8'h08 held indefinitely, timeout=0.
REQ-033 rst_n=0 for one edge during a grant of idx 3 -> gnt=8'h00 at that edge; after release of reset with req=8'h08 -> grant of idx 3 from ptr=0.
